// File: rtl/computie_bus_record_serializer.sv
// Bus snooper records -> FIFO -> fixed byte frames {A|mod, addr MSB first, data MSB first[, xor csum]} on a byte stream.
// Latency: a record pushed into an empty idle block shows its header one cycle after the pop edge (pop on the edge after the push).
// Backpressure: tx_data/tx_valid hold while !tx_ready; record_ready drops when full, flushing or in reset. Option: COMPUTIE_RECORD_CHECKSUM_EN.
module computie_bus_record_serializer #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 32
) (
    input  logic                      comm_clock,
    input  logic                      comm_reset,
    input  logic                      record_valid,
    output logic                      record_ready,
    input  logic [2*BITWIDTH+1:0]     record_in,
    input  logic                      flush,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      busy
);

    localparam int NB = BITWIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = 2 * BITWIDTH + 2;

`ifdef COMPUTIE_RECORD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_DATA, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_DATA} state_t;
`endif

    // Byte idx of v, counted from the most significant byte.
    function automatic logic [7:0] sel_byte(input logic [BITWIDTH-1:0] v, input logic [IW-1:0] idx);
        logic [BITWIDTH-1:0] sh;
        sh = v >> (8 * (NB - 1 - int'(idx)));
        return sh[7:0];
    endfunction

`ifdef COMPUTIE_RECORD_CHECKSUM_EN
    function automatic logic [7:0] xor_fold(input logic [BITWIDTH-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NB; i++) acc = acc ^ v[8*i +: 8];
        return acc;
    endfunction
`endif

    logic [RW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;

    state_t              r_state;
    logic [IW-1:0]       r_byte_idx;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic [1:0]          r_mod;
    logic [BITWIDTH-1:0] r_addr;
    logic [BITWIDTH-1:0] r_data;

    state_t              w_state_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [7:0]          w_txd_nxt;
    logic                w_txv_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_can_pop;
    logic                w_take;
    logic                w_frame_end;
    logic [RW-1:0]       w_head;
    logic [7:0]          w_head_hdr;

    assign w_full       = (r_count == (AW+1)'(DEPTH));
    // A flush in the same cycle empties the FIFO, so nothing may be popped then.
    assign w_can_pop    = (r_count != '0) && !flush;
    assign record_ready = !w_full && !flush && !comm_reset;
    assign w_push       = record_valid && record_ready;
    assign w_take       = r_tx_valid && tx_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_hdr   = {4'hA, 2'b00, w_head[RW-1 -: 2]};

    always_ff @(posedge comm_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= record_in;
    end

    always_ff @(posedge comm_clock) begin
        if (comm_reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_byte_idx;
        w_txd_nxt   = r_tx_data;
        w_txv_nxt   = r_tx_valid;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_pop       = 1'b1;
                    w_txd_nxt   = w_head_hdr;
                    w_txv_nxt   = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_take) begin
                    w_txd_nxt   = sel_byte(r_addr, '0);
                    w_idx_nxt   = '0;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_take) begin
                    if (r_byte_idx == IW'(NB - 1)) begin
                        w_txd_nxt   = sel_byte(r_data, '0);
                        w_idx_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_idx_nxt = r_byte_idx + IW'(1);
                        w_txd_nxt = sel_byte(r_addr, r_byte_idx + IW'(1));
                    end
                end
            end
            S_DATA: begin
                if (w_take) begin
                    if (r_byte_idx == IW'(NB - 1)) begin
`ifdef COMPUTIE_RECORD_CHECKSUM_EN
                        w_txd_nxt   = {4'hA, 2'b00, r_mod} ^ xor_fold(r_addr) ^ xor_fold(r_data);
                        w_state_nxt = S_CSUM;
`else
                        w_frame_end = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = r_byte_idx + IW'(1);
                        w_txd_nxt = sel_byte(r_data, r_byte_idx + IW'(1));
                    end
                end
            end
`ifdef COMPUTIE_RECORD_CHECKSUM_EN
            S_CSUM: begin
                if (w_take) w_frame_end = 1'b1;
            end
`endif
            default: begin
                w_txv_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Last byte taken: chain straight into the next frame when one is queued.
        if (w_frame_end) begin
            if (w_can_pop) begin
                w_pop       = 1'b1;
                w_txd_nxt   = w_head_hdr;
                w_txv_nxt   = 1'b1;
                w_state_nxt = S_HEADER;
            end else begin
                w_txv_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_mod      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_idx_nxt;
            r_tx_data  <= w_txd_nxt;
            r_tx_valid <= w_txv_nxt;
            if (w_pop) begin
                r_mod  <= w_head[RW-1 -: 2];
                r_addr <= w_head[2*BITWIDTH-1 -: BITWIDTH];
                r_data <= w_head[BITWIDTH-1:0];
            end
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: doc/computie_bus_record_serializer.md
Name: computie_bus_record_serializer

Overview:
- Sits directly downstream of the bus snooper and consumes its record stream: {mod[1:0], address, data}.
- Buffers records in a FIFO and serialises each one into a fixed byte frame on a valid/ready byte stream feeding the comm-side UART transmitter.
- Entirely in the comm_clock domain. The record handshake arrives already synchronised to comm_clock; the CDC stage lives outside this block.

Parameters:
- BITWIDTH, 32, address/data width in bits; must be a multiple of 8; NB = BITWIDTH/8.
- DEPTH, 32, FIFO entries; power of two, at least 2.

Ports:
- comm_clock  input  1  sole clock, rising edge.
- comm_reset  input  1  synchronous, active-high reset.
- record_valid  input  1  upstream record present.
- record_ready  output  1  block accepts record this cycle.
- record_in  input  2*BITWIDTH+2  {mod[1:0], address, data}.
- flush  input  1  discard all FIFO contents.
- tx_valid  output  1  byte on tx_data valid.
- tx_ready  input  1  UART accepts byte.
- tx_data  output  8  frame byte.
- fifo_count  output  $clog2(DEPTH)+1  entries currently stored.
- busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset values, held while comm_reset is high and on the first cycle after:
  - FIFO empty, fifo_count=0, tx_valid=0, tx_data=8'h00, busy=0, serialiser in IDLE.
  - record_ready=0 while comm_reset is high.
- record_ready = !full && !flush && !comm_reset (combinational). A push happens on an edge where record_valid && record_ready.
- FIFO:
  - Write and read pointers wrap modulo DEPTH.
  - fifo_count = writes minus reads, range 0..DEPTH. It is full at DEPTH.
  - A push and a pop on the same edge leave fifo_count unchanged and are legal at any fill level, including when the FIFO holds 1 entry.
- flush: on the edge it is sampled high, both pointers reset and fifo_count=0. Any frame already loaded in the serialiser completes unaffected.
- Frame format, per record, in order:
  - Byte 0 (header): {4'hA, 2'b00, mod}.
  - Bytes 1..NB: address, MSB byte first.
  - Bytes NB+1..2NB: data, MSB byte first.
- Serialiser states: IDLE, HEADER, ADDR, DATA.
  - IDLE: if the FIFO is non-empty, pop the head into the frame register, drive the header onto tx_data, set tx_valid=1, go to HEADER.
  - HEADER: when tx_ready is high, load the address MSB byte, set byte_idx=0, go to ADDR.
  - ADDR: each tx_ready advances byte_idx. After byte NB-1 is taken, load the data MSB byte, reset byte_idx, go to DATA.
  - DATA: the same, per byte. After the last byte is taken:
    - FIFO non-empty: pop the next record and present its header on the next cycle, with no idle cycle (back-to-back frames).
    - FIFO empty: tx_valid=0 and go to IDLE.
- Stream rules:
  - tx_data is registered and holds stable while tx_valid && !tx_ready.
  - tx_valid never drops until its byte is taken.
  - A byte transfers on an edge where tx_valid && tx_ready.
- Latency: a record pushed into an empty FIFO with the serialiser in IDLE on edge N pops on edge N+1. Its header is visible with tx_valid=1 in the cycle after edge N+1.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: the frame is abandoned immediately, with no partial completion. tx_valid=0 on the next cycle.
- Simultaneous push with the pop at an end-of-frame: both take effect; fifo_count is unchanged.

Optional Feature:
- Macro: COMPUTIE_RECORD_CHECKSUM_EN.
- Defined:
  - A CSUM state follows DATA.
  - One extra byte is sent, equal to the XOR of all preceding bytes of the frame, header included.
  - Frame length is 2NB+2.
  - Back-to-back and IDLE transitions occur after the CSUM byte instead of after the last data byte.
- Undefined: no CSUM state; frame length is 2NB+1; there is no checksum logic.

Test Plan:
- Single record, tx_ready tied high, record_in={2'b01, 32'h12345678, 32'hDEADBEEF} -> tx_data sequence A1 12 34 56 78 DE AD BE EF on consecutive cycles. With the checksum macro defined, the ninth byte is followed by the XOR of those nine bytes. busy falls one cycle after the last byte.
- tx_ready backpressure: toggle tx_ready every 3 cycles -> tx_data/tx_valid stay stable while stalled; the byte order is identical to the first scenario; no byte is duplicated or dropped.
- Fill: tx_ready=0, push 33 records with DEPTH=32 -> the first record pops into the serialiser, so 32 more fit. The 33rd push is accepted with fifo_count going to 32, then record_ready=0. Releasing tx_ready drains 33 frames in push order, back-to-back with no gap cycles.
- Simultaneous push and pop at a frame boundary with fifo_count=1 -> count stays 1. The next header follows the previous last byte on the very next cycle.
- flush while a frame is mid-ADDR with 5 records queued -> the current frame completes all bytes, fifo_count=0, tx_valid=0 after it. record_ready=0 during the flush cycle.
- comm_reset asserted mid-DATA -> tx_valid=0 and fifo_count=0 the next cycle. After reset, a new record produces a clean header byte.
